// File: rtl/regbank_pkg.sv
// Shared constants and requester encoding for the register-bank write arbiter.
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int LINK_REG = 31;
  localparam int DIV_REG  = 30;

  typedef enum logic [1:0] {
    REQ_WB   = 2'd0,
    REQ_LINK = 2'd1,
    REQ_DIV  = 2'd2,
    REQ_NONE = 2'd3
  } req_idx_e;

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    logic [31:0] v;
    v      = 32'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_aging_counter.sv
// Saturating wait counter; a request that has waited MAX_WAIT eligible cycles is promoted.
module aging_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic eligible,
  input  logic granted,
  output logic promoted
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt_r;

  // Count refused eligible cycles; a grant or a dropped request starts the wait over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (granted || !req) begin
      cnt_r <= {CW{1'b0}};
    end else if (eligible && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign promoted = (cnt_r == MAX_C);

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank write port among WB, LINK (fixed R31) and DIV (fixed R30),
// with aging so LINK/DIV cannot starve, and publishes a pending-write mask.
module regbank_write_arbiter #(
  parameter int DATA_W   = regbank_pkg::DATA_W,
  parameter int ADDR_W   = regbank_pkg::ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int LINK_REG = regbank_pkg::LINK_REG,
  parameter int DIV_REG  = regbank_pkg::DIV_REG,
  parameter int DROP_R0  = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              WbReq,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  output logic              WbAck,
  input  logic              LinkReq,
  input  logic [DATA_W-1:0] LinkData,
  output logic              LinkAck,
  input  logic              DivReq,
  input  logic [DATA_W-1:0] DivData,
  output logic              DivAck,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic [31:0]       PendMask,
  output logic              Starve
);

  import regbank_pkg::*;

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] DIV_ADDR  = ADDR_W'(DIV_REG);

  logic     wb_elig_s, link_elig_s, div_elig_s;
  logic     link_aged_s, div_aged_s;
  logic     link_prom_s, div_prom_s, starve_s;
  logic     wb_drop_s;
  req_idx_e sel_s;
  logic [31:0] pend_s;

  // A requester is ignored in the cycle its own Ack is visible.
  assign wb_elig_s   = WbReq & ~WbAck;
  assign link_elig_s = LinkReq & ~LinkAck;
  assign div_elig_s  = DivReq & ~DivAck;
  assign link_prom_s = link_elig_s & link_aged_s;
  assign div_prom_s  = div_elig_s & div_aged_s;
  assign starve_s    = link_prom_s & div_prom_s;
  assign wb_drop_s   = (DROP_R0 != 0) && (WbAddr == {ADDR_W{1'b0}});

  aging_counter #(.MAX_WAIT(MAX_WAIT)) u_link_age (
    .clk      (CLK),
    .rst      (Reset),
    .req      (LinkReq),
    .eligible (link_elig_s),
    .granted  (sel_s == REQ_LINK),
    .promoted (link_aged_s)
  );

  aging_counter #(.MAX_WAIT(MAX_WAIT)) u_div_age (
    .clk      (CLK),
    .rst      (Reset),
    .req      (DivReq),
    .eligible (div_elig_s),
    .granted  (sel_s == REQ_DIV),
    .promoted (div_aged_s)
  );

  // Priority: promoted LINK, promoted DIV, WB, LINK, DIV.
  always_comb begin
    sel_s = REQ_NONE;
    if (link_prom_s) begin
      sel_s = REQ_LINK;
    end else if (div_prom_s) begin
      sel_s = REQ_DIV;
    end else if (wb_elig_s) begin
      sel_s = REQ_WB;
    end else if (link_elig_s) begin
      sel_s = REQ_LINK;
    end else if (div_elig_s) begin
      sel_s = REQ_DIV;
    end else begin
      sel_s = REQ_NONE;
    end
  end

  // Grant register: acks, write-port drive and starvation flag all appear one edge later.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      WbAck   <= 1'b0;
      LinkAck <= 1'b0;
      DivAck  <= 1'b0;
      WrEn    <= 1'b0;
      WrAddr  <= {ADDR_W{1'b0}};
      WrData  <= {DATA_W{1'b0}};
      Starve  <= 1'b0;
    end else begin
      WbAck   <= (sel_s == REQ_WB);
      LinkAck <= (sel_s == REQ_LINK);
      DivAck  <= (sel_s == REQ_DIV);
      Starve  <= starve_s;
      case (sel_s)
        REQ_WB: begin
          WrEn   <= ~wb_drop_s;
          WrAddr <= WbAddr;
          WrData <= WbData;
        end
        REQ_LINK: begin
          WrEn   <= 1'b1;
          WrAddr <= LINK_ADDR;
          WrData <= LinkData;
        end
        REQ_DIV: begin
          WrEn   <= 1'b1;
          WrAddr <= DIV_ADDR;
          WrData <= DivData;
        end
        default: begin
          WrEn   <= 1'b0;
          WrAddr <= WrAddr;
          WrData <= WrData;
        end
      endcase
    end
  end

  // Pending writes: every eligible request plus the write currently on the port.
  always_comb begin
    pend_s = 32'd0;
    pend_s = pend_s | (wb_elig_s   ? onehot32(WbAddr)    : 32'd0);
    pend_s = pend_s | (link_elig_s ? onehot32(LINK_ADDR) : 32'd0);
    pend_s = pend_s | (div_elig_s  ? onehot32(DIV_ADDR)  : 32'd0);
    pend_s = pend_s | (WrEn        ? onehot32(WrAddr)    : 32'd0);
    if (DROP_R0 != 0) begin
      pend_s[0] = 1'b0;
    end else begin
      pend_s[0] = pend_s[0];
    end
  end

  assign PendMask = pend_s;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized scoreboard bench: two arbiters (MAX_WAIT=4 and MAX_WAIT=1) checked against a
// cycle-level reference model of the arbitration rules.
module tb_regbank_write_arbiter;

  localparam int NDUT = 2;

  typedef struct packed {
    logic [31:0] due;
    logic [2:0]  acks;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        starve;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] wb_req, link_req, div_req;
  logic [4:0]      wb_addr   [NDUT];
  logic [31:0]     wb_data   [NDUT];
  logic [31:0]     link_data [NDUT];
  logic [31:0]     div_data  [NDUT];
  logic [NDUT-1:0] wb_ack, link_ack, div_ack, wr_en, starve;
  logic [4:0]      wr_addr   [NDUT];
  logic [31:0]     wr_data   [NDUT];
  logic [31:0]     pend      [NDUT];

  regbank_write_arbiter #(.MAX_WAIT(4)) dut (
    .CLK(clk), .Reset(rst),
    .WbReq(wb_req[0]), .WbAddr(wb_addr[0]), .WbData(wb_data[0]), .WbAck(wb_ack[0]),
    .LinkReq(link_req[0]), .LinkData(link_data[0]), .LinkAck(link_ack[0]),
    .DivReq(div_req[0]), .DivData(div_data[0]), .DivAck(div_ack[0]),
    .WrEn(wr_en[0]), .WrAddr(wr_addr[0]), .WrData(wr_data[0]),
    .PendMask(pend[0]), .Starve(starve[0])
  );

  regbank_write_arbiter #(.MAX_WAIT(1)) dut_w1 (
    .CLK(clk), .Reset(rst),
    .WbReq(wb_req[1]), .WbAddr(wb_addr[1]), .WbData(wb_data[1]), .WbAck(wb_ack[1]),
    .LinkReq(link_req[1]), .LinkData(link_data[1]), .LinkAck(link_ack[1]),
    .DivReq(div_req[1]), .DivData(div_data[1]), .DivAck(div_ack[1]),
    .WrEn(wr_en[1]), .WrAddr(wr_addr[1]), .WrData(wr_data[1]),
    .PendMask(pend[1]), .Starve(starve[1])
  );

  // Reference model state; requester index 0=WB, 1=LINK, 2=DIV.
  int          mw        [NDUT];
  logic        m_req     [NDUT][3];
  logic [4:0]  m_addr    [NDUT][3];
  logic [31:0] m_data    [NDUT][3];
  logic        m_acked   [NDUT][3];
  int          m_wait    [NDUT][3];
  int          m_gnt     [NDUT];
  logic        m_cw_valid[NDUT];
  logic [4:0]  m_cw_addr [NDUT];
  logic [31:0] exp_pend  [NDUT];
  exp_t        q         [NDUT][$];

  int unsigned rate   [3];
  logic        pre_en [3];
  logic [4:0]  pre_addr [3];
  logic [31:0] pre_data [3];

  int cyc;
  int tests;
  int fails;

  function automatic logic [4:0] dest_of(input int i, input logic [4:0] a);
    case (i)
      0:       return a;
      1:       return 5'd31;
      default: return 5'd30;
    endcase
  endfunction

  function automatic logic [31:0] pend_model(input int d);
    logic [31:0] m;
    m = m_cw_valid[d] ? (32'd1 << m_cw_addr[d]) : 32'd0;
    for (int i = 0; i < 3; i++)
      if (m_req[d][i] && m_gnt[d] != i) m = m | (32'd1 << dest_of(i, m_addr[d][i]));
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [4:0] rand_addr();
    case ($urandom_range(7))
      0:       return 5'd0;
      1:       return 5'd30;
      2:       return 5'd31;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  task automatic stim(input int d);
    for (int i = 0; i < 3; i++) begin
      if (m_acked[d][i]) m_req[d][i] = 1'b0;
      if (!m_req[d][i]) begin
        if (pre_en[i]) begin
          m_req[d][i] = 1'b1; m_addr[d][i] = pre_addr[i]; m_data[d][i] = pre_data[i];
        end else if ($urandom_range(99) < rate[i]) begin
          m_req[d][i] = 1'b1; m_addr[d][i] = rand_addr(); m_data[d][i] = $urandom();
        end
      end
    end
    wb_req[d]    = m_req[d][0];
    wb_addr[d]   = m_addr[d][0];
    wb_data[d]   = m_data[d][0];
    link_req[d]  = m_req[d][1];
    link_data[d] = m_data[d][1];
    div_req[d]   = m_req[d][2];
    div_data[d]  = m_data[d][2];
  endtask

  task automatic eval(input int d);
    logic elig [3];
    logic prom_l, prom_d;
    int   w;
    exp_t e;
    for (int i = 0; i < 3; i++) elig[i] = m_req[d][i] && (m_gnt[d] != i);
    exp_pend[d] = pend_model(d);
    prom_l = elig[1] && (m_wait[d][1] == mw[d]);
    prom_d = elig[2] && (m_wait[d][2] == mw[d]);
    if (prom_l)       w = 1;
    else if (prom_d)  w = 2;
    else if (elig[0]) w = 0;
    else if (elig[1]) w = 1;
    else if (elig[2]) w = 2;
    else              w = -1;
    e = '0;
    if (w >= 0) begin
      e.due    = 32'(cyc + 1);
      e.acks   = 3'(1 << w);
      e.wren   = !(w == 0 && m_addr[d][0] == 5'd0);
      e.addr   = dest_of(w, m_addr[d][0]);
      e.data   = m_data[d][w];
      e.starve = prom_l && prom_d;
      q[d].push_back(e);
    end
    for (int i = 1; i < 3; i++) begin
      if (w == i || !m_req[d][i]) m_wait[d][i] = 0;
      else if (elig[i]) m_wait[d][i] = (m_wait[d][i] + 1 > mw[d]) ? mw[d] : m_wait[d][i] + 1;
    end
    for (int i = 0; i < 3; i++) m_acked[d][i] = (m_gnt[d] == i);
    m_cw_valid[d] = (w >= 0) && e.wren;
    m_cw_addr[d]  = e.addr;
    m_gnt[d]      = w;
  endtask

  task automatic reset_model(input int d);
    q[d].delete();
    m_gnt[d] = -1;
    m_cw_valid[d] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_acked[d][i] = 1'b0;
      m_wait[d][i]  = 0;
    end
    exp_pend[d] = pend_model(d);
  endtask

  task automatic cycle_body();
    cyc++;
    for (int d = 0; d < NDUT; d++) stim(d);
    for (int i = 0; i < 3; i++) pre_en[i] = 1'b0;
    for (int d = 0; d < NDUT; d++) eval(d);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cycle_body();
    end
  endtask

  task automatic issue(input int i, input logic [4:0] a, input logic [31:0] dv);
    pre_en[i] = 1'b1; pre_addr[i] = a; pre_data[i] = dv;
  endtask

  task automatic set_rates(input int unsigned w, input int unsigned l, input int unsigned v);
    rate[0] = w; rate[1] = l; rate[2] = v;
  endtask

  // Reset lands mid-cycle, after the edge that may have raised a grant.
  task automatic reset_mid();
    #1;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) reset_model(d);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_body();
  endtask

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL dut%0d %s cyc %0d: got %h expected %h", d, name, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic [2:0] acks;
    exp_t e;
    acks = {div_ack[d], link_ack[d], wb_ack[d]};
    chk(d, "pend_mask", pend[d], exp_pend[d]);
    if (q[d].size() > 0 && q[d][0].due <= 32'(cyc)) begin
      e = q[d].pop_front();
      chk(d, "acks", 32'(acks), 32'(e.acks));
      chk(d, "wr_en", 32'(wr_en[d]), 32'(e.wren));
      chk(d, "starve", 32'(starve[d]), 32'(e.starve));
      if (e.wren) begin
        chk(d, "wr_addr", 32'(wr_addr[d]), 32'(e.addr));
        chk(d, "wr_data", wr_data[d], e.data);
      end
    end else begin
      chk(d, "idle_acks", 32'(acks), 32'd0);
      chk(d, "idle_wr_en", 32'(wr_en[d]), 32'd0);
      chk(d, "idle_starve", 32'(starve[d]), 32'd0);
    end
  endtask

  // Monitor: compares both arbiters against the scoreboard away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) check_dut(d);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b1;
    mw[0] = 4; mw[1] = 1;
    set_rates(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pre_en[i] = 1'b0; pre_addr[i] = 5'd0; pre_data[i] = 32'd0;
    end
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 3; i++) begin
        m_req[d][i] = 1'b0; m_addr[d][i] = 5'd0; m_data[d][i] = 32'd0;
      end
      reset_model(d);
      wb_req[d] = 1'b0; wb_addr[d] = 5'd0; wb_data[d] = 32'd0;
      link_req[d] = 1'b0; link_data[d] = 32'd0;
      div_req[d] = 1'b0; div_data[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_body();

    issue(0, 5'd5, 32'hDEAD_BEEF);
    step(4);
    issue(0, 5'd12, 32'h0000_0C0C);
    issue(1, 5'd0, 32'h0000_0400);
    issue(2, 5'd0, 32'h0000_0007);
    step(6);
    set_rates(100, 0, 100);
    step(20);
    set_rates(0, 0, 0);
    step(5);
    issue(0, 5'd0, 32'h1234_5678);
    step(4);
    set_rates(100, 100, 100);
    step(30);
    set_rates(0, 0, 0);
    step(6);
    issue(0, 5'd9, 32'hCAFE_0009);
    step(2);
    reset_mid();
    step(4);

    for (int b = 0; b < 8; b++) begin
      set_rates($urandom_range(100), $urandom_range(100), $urandom_range(100));
      step(250);
      if (b == 3) reset_mid();
    end
    set_rates(0, 0, 0);
    step(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
Shares the register bank's single write port among three writeback sources: the main writeback stage (any register), the jump-and-link unit (fixed R31) and the divider (fixed R30). Grants at most one write per cycle using fixed priority with aging, so LINK and DIV cannot starve. Publishes a pending-write mask to the hazard unit so reads of not-yet-written registers can be stalled. Sits between the writeback stage and the register bank, driving the bank's RegWrite/RegEscrita/DadoEscrita inputs; the bank's RDiv and JLink inputs are tied low.

Parameters:
DATA_W, 32, data width
ADDR_W, 5, register address width
MAX_WAIT, 4, cycles a waiting LINK/DIV request is refused before it is promoted
LINK_REG, 31, destination register for LINK
DIV_REG, 30, destination register for DIV
DROP_R0, 1, 1 = WB writes to R0 are acknowledged but produce no write

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
WbReq  in  1  writeback request
WbAddr  in  ADDR_W  writeback destination
WbData  in  DATA_W  writeback data
WbAck  out  1  one-cycle grant pulse to WB
LinkReq  in  1  link request
LinkData  in  DATA_W  return address
LinkAck  out  1  one-cycle grant pulse to LINK
DivReq  in  1  divider request
DivData  in  DATA_W  divider result
DivAck  out  1  one-cycle grant pulse to DIV
WrEn  out  1  to bank RegWrite
WrAddr  out  ADDR_W  to bank RegEscrita
WrData  out  DATA_W  to bank DadoEscrita
PendMask  out  32  bit r set = register r has an outstanding or in-flight write
Starve  out  1  a promoted request lost arbitration to another promoted request

Behaviour:
- Reset (async, active-high) clears WbAck, LinkAck, DivAck, WrEn, WrAddr, WrData, Starve and both wait counters to 0. Assertion mid-grant discards the grant; no write is issued.
- Handshake: the requester holds Req, address and data stable until it sees Ack. Ack is registered and lasts exactly one cycle. A requester's Req is ignored in the cycle its Ack is high (blackout), so each requester gets at most one grant per 2 cycles.
- Eligible = Req high and not in blackout.
- Selection priority: promoted LINK, then promoted DIV, then WB, then LINK, then DIV.
- Latency: a request eligible in cycle n is granted at rising edge n+1. In cycle n+1, WrEn/WrAddr/WrData and the matching Ack are high. The bank commits the write on the falling edge of cycle n+1.
- Destinations and data: WrAddr = LINK_REG for LINK, DIV_REG for DIV, WbAddr for WB. WrData = the selected requester's data.
- R0 drop: when DROP_R0=1 and a WB grant has WbAddr=0, WbAck pulses but WrEn stays 0.
- Idle: with no grant, WrEn=0 and WrAddr/WrData hold their previous values.
- Aging, per LINK and DIV: the counter increments each cycle the requester is eligible but not granted, saturating at MAX_WAIT. It clears on grant or when Req is low. Counter == MAX_WAIT marks the request as promoted.
- Starve is registered high for one cycle when both LINK and DIV are promoted and DIV loses.
- Simultaneous WB write to R30/R31 with a DIV/LINK request: both writes are granted in priority order on different cycles. The last grant wins; no merging.
- PendMask is combinational:
  - OR of one-hot(destination) for every eligible requester;
  - one-hot(WrAddr) when WrEn=1;
  - bit 0 forced 0 when DROP_R0=1.

Decomposition:
- Shared package regbank_pkg: DATA_W/ADDR_W constants, LINK_REG/DIV_REG indices, requester-index encoding (WB=0, LINK=1, DIV=2).
- One sub-module is natural: aging_counter (saturating wait counter with promote output), instantiated twice for LINK and DIV.
- Selection and one-hot decode stay in the top level.

Test Plan:
- Single WB request, WbAddr=5, WbData=0xDEADBEEF, held from cycle 0 -> cycle 1: WrEn=1, WrAddr=5, WrData=0xDEADBEEF, WbAck=1. Cycle 2: WrEn=0. PendMask bit 5 set in cycles 0-1 only.
- WB, LINK and DIV all assert in cycle 0 and hold until acked (LINK=0x400, DIV=0x7) -> grant order WB(1), LINK(2), DIV(3). WrAddr is 31 in cycle 2 and 30 in cycle 3. Each Ack pulses exactly once.
- Back-to-back WB requests every cycle, DivReq held, MAX_WAIT=4 -> DivAck no later than cycle 5. DIV wait counter is 0 after the grant.
- WB write to R0 with DROP_R0=1 -> WbAck=1, WrEn=0, PendMask[0]=0 throughout.
- LINK and DIV both promoted (WB saturating) -> LINK granted first, then DIV. Starve=1 for one cycle, coincident with LinkAck.
- Reset asserted asynchronously mid-cycle while WrEn=1 -> WrEn, all Acks and counters go to 0 immediately. Requests held through reset are re-granted at the first edge after Reset deasserts.
